// File: rtl/counter_share_sched.sv
// counter_share_sched: round-robin scheduler that time-shares one loadable
// up/down counter among NREQ requesters. Each job loads a start value, counts
// LEN steps in the requested direction and returns the final count.
module counter_share_sched #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned W    = 8,
   parameter int unsigned LW   = 4
) (
   input  logic               clk,
   input  logic               rst_,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*W-1:0]  req_val,
   input  logic [NREQ-1:0]    req_up,
   input  logic [NREQ*LW-1:0] req_len,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    done,
   output logic [W-1:0]       result,
   output logic               busy,
   output logic               ld_cnt_,
   output logic               updn_cnt,
   output logic               count_enb,
   output logic [W-1:0]       data_in,
   input  logic [W-1:0]       data_out
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_COUNT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state_q;
   state_t          state_d;

   logic [PW-1:0]   rr_q;
   logic [PW-1:0]   rr_nxt;
   logic            up_q;
   logic [LW-1:0]   len_q;
   logic [LW-1:0]   step_q;

   logic            win_vld;
   logic [PW-1:0]   win_idx;
   logic [NREQ-1:0] win_oh;
   logic            grant_c;

   // Round-robin search: first set req bit at or above rr_q, wrapping mod NREQ
   always_comb begin
      int k;
      k       = 0;
      win_vld = 1'b0;
      win_idx = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         k = int'(rr_q) + i;
         if (k >= int'(NREQ)) begin
            k = k - int'(NREQ);
         end
         if (!win_vld && req[k]) begin
            win_vld = 1'b1;
            win_idx = PW'(k);
         end
      end
   end

   // Grant decode and pointer advance (winner+1 mod NREQ)
   always_comb begin
      grant_c = (state_q == S_IDLE) && win_vld;
      win_oh  = NREQ'(1) << win_idx;
      if (32'(win_idx) == NREQ - 1) begin
         rr_nxt = '0;
      end else begin
         rr_nxt = win_idx + PW'(1);
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (len_q != '0) begin
               state_d = S_COUNT;
            end else begin
               state_d = S_DONE;
            end
         end
         S_COUNT: begin
            if (step_q == LW'(1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Job latch at the grant edge, rr pointer, and the step counter
   always_ff @(posedge clk) begin
      if (!rst_) begin
         rr_q   <= '0;
         up_q   <= 1'b0;
         len_q  <= '0;
         step_q <= '0;
      end else begin
         if (grant_c) begin
            rr_q  <= rr_nxt;
            up_q  <= req_up[win_idx];
            len_q <= req_len[32'(win_idx)*LW +: LW];
         end
         if (state_q == S_LOAD) begin
            step_q <= len_q;
         end else if (state_q == S_COUNT) begin
            step_q <= step_q - LW'(1);
         end
      end
   end

   // Registered Moore outputs, decoded from the upcoming state
   always_ff @(posedge clk) begin
      if (!rst_) begin
         gnt       <= '0;
         done      <= '0;
         busy      <= 1'b0;
         ld_cnt_   <= 1'b1;
         count_enb <= 1'b0;
         updn_cnt  <= 1'b0;
         data_in   <= '0;
      end else begin
         busy      <= (state_d != S_IDLE);
         ld_cnt_   <= (state_d != S_LOAD);
         count_enb <= (state_d == S_COUNT);
         updn_cnt  <= (state_d == S_COUNT) && up_q;
         done      <= (state_d == S_DONE) ? gnt : '0;
         if (grant_c) begin
            gnt     <= win_oh;
            data_in <= req_val[32'(win_idx)*W +: W];
         end else if (state_d == S_IDLE) begin
            gnt     <= '0;
         end
      end
   end

   // The counter settles on its last step at the edge entering DONE, so the
   // final value can only be forwarded combinationally during that cycle.
   assign result = (state_q == S_DONE) ? data_out : '0;

endmodule

// File: tb/tb_counter_share_sched.sv
// Directed bench for counter_share_sched with a behavioural counter attached.
module tb_counter_share_sched;

   localparam int unsigned NREQ = 4;
   localparam int unsigned W    = 8;
   localparam int unsigned LW   = 4;

   logic               clk = 1'b0;
   logic               rst_;
   logic [NREQ-1:0]    req;
   logic [NREQ*W-1:0]  req_val;
   logic [NREQ-1:0]    req_up;
   logic [NREQ*LW-1:0] req_len;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    done;
   logic [W-1:0]       result;
   logic               busy;
   logic               ld_cnt_;
   logic               updn_cnt;
   logic               count_enb;
   logic [W-1:0]       data_in;
   logic [W-1:0]       data_out;

   logic [W-1:0]       cnt;
   logic               inv_on;
   int                 vec_cnt = 0;
   int                 err_cnt = 0;

   counter_share_sched #(.NREQ(NREQ), .W(W), .LW(LW)) dut (
      .clk       (clk),
      .rst_      (rst_),
      .req       (req),
      .req_val   (req_val),
      .req_up    (req_up),
      .req_len   (req_len),
      .gnt       (gnt),
      .done      (done),
      .result    (result),
      .busy      (busy),
      .ld_cnt_   (ld_cnt_),
      .updn_cnt  (updn_cnt),
      .count_enb (count_enb),
      .data_in   (data_in),
      .data_out  (data_out)
   );

   always #5 clk = ~clk;

   // Shared 8-bit loadable up/down counter driven by the scheduler
   always @(posedge clk) begin
      if (!ld_cnt_) begin
         cnt <= data_in;
      end else if (count_enb) begin
         cnt <= updn_cnt ? cnt + 8'd1 : cnt - 8'd1;
      end
   end
   assign data_out = cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Structural invariants, sampled on the falling edge
   always @(negedge clk) begin
      if (inv_on) begin
         chk("ld_cen_excl", 32'(!ld_cnt_ && count_enb), 32'd0);
         chk("done_in_gnt", 32'(done & ~gnt), 32'd0);
         chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int idx, input logic [W-1:0] val, input logic up, input int len);
      req_val[idx*W +: W]   = val;
      req_up[idx]           = up;
      req_len[idx*LW +: LW] = LW'(len);
   endtask

   task automatic wait_gnt();
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (gnt == '0 && n < 20);
      chk("gnt_seen", 32'(gnt != '0), 32'd1);
   endtask

   // Follow one job from grant to done; drop_at > 0 deasserts req in that
   // cycle after LOAD, keep leaves req asserted past done.
   task automatic run_job(input int idx, input logic [W-1:0] dval, input logic up,
                          input logic [W-1:0] exp, input int exp_len,
                          input int drop_at, input bit keep);
      int n;
      int ncen;
      bit first;
      wait_gnt();
      chk("grant", 32'(gnt), 32'(1 << idx));
      chk("load_ld", 32'(ld_cnt_), 32'd0);
      chk("load_din", 32'(data_in), 32'(dval));
      chk("load_cen", 32'(count_enb), 32'd0);
      chk("load_busy", 32'(busy), 32'd1);
      n     = 0;
      ncen  = 0;
      first = 1'b1;
      tick();
      while (done == '0 && n < 40) begin
         if (count_enb) begin
            ncen++;
            if (first) begin
               chk("updn", 32'(updn_cnt), 32'(up));
               first = 1'b0;
            end
         end
         n++;
         if (n == drop_at) begin
            req[idx] = 1'b0;
         end
         tick();
      end
      chk("done", 32'(done), 32'(1 << idx));
      chk("result", 32'(result), 32'(exp));
      chk("steps", 32'(ncen), 32'(exp_len));
      chk("done_cen", 32'(count_enb), 32'd0);
      if (!keep) begin
         req[idx] = 1'b0;
      end
      tick();
      chk("done_once", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_gnt", 32'(gnt), 32'd0);
   endtask

   initial begin
      inv_on  = 1'b0;
      rst_    = 1'b0;
      req     = '0;
      req_val = '0;
      req_up  = '0;
      req_len = '0;
      repeat (2) tick();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ld", 32'(ld_cnt_), 32'd1);
      chk("rst_cen", 32'(count_enb), 32'd0);
      chk("rst_updn", 32'(updn_cnt), 32'd0);
      chk("rst_din", 32'(data_in), 32'd0);
      inv_on = 1'b1;
      rst_   = 1'b1;

      // T1 single up
      set_op(0, 8'h10, 1'b1, 5);
      req[0] = 1'b1;
      run_job(0, 8'h10, 1'b1, 8'h15, 5, -1, 1'b0);

      // T2 down with wrap
      set_op(1, 8'h02, 1'b0, 4);
      req[1] = 1'b1;
      run_job(1, 8'h02, 1'b0, 8'hFE, 4, -1, 1'b0);

      // T3 zero length
      set_op(2, 8'hA5, 1'b1, 0);
      req[2] = 1'b1;
      run_job(2, 8'hA5, 1'b1, 8'hA5, 0, -1, 1'b0);

      // T4 contention: all four held from reset, then 0 and 2 held
      rst_ = 1'b0;
      set_op(0, 8'h03, 1'b1, 1);
      set_op(1, 8'h43, 1'b0, 2);
      set_op(2, 8'h83, 1'b1, 3);
      set_op(3, 8'hC3, 1'b0, 4);
      req = 4'hF;
      tick();
      rst_ = 1'b1;
      run_job(0, 8'h03, 1'b1, 8'h04, 1, -1, 1'b0);
      run_job(1, 8'h43, 1'b0, 8'h41, 2, -1, 1'b0);
      run_job(2, 8'h83, 1'b1, 8'h86, 3, -1, 1'b0);
      run_job(3, 8'hC3, 1'b0, 8'hBF, 4, -1, 1'b0);
      req = 4'b0101;
      run_job(0, 8'h03, 1'b1, 8'h04, 1, -1, 1'b1);
      run_job(2, 8'h83, 1'b1, 8'h86, 3, -1, 1'b1);
      run_job(0, 8'h03, 1'b1, 8'h04, 1, -1, 1'b1);
      req[0] = 1'b0;
      run_job(2, 8'h83, 1'b1, 8'h86, 3, -1, 1'b0);

      // T5 reset on the third COUNT cycle
      set_op(0, 8'h50, 1'b1, 6);
      req = 4'b0001;
      wait_gnt();
      chk("t5_grant", 32'(gnt), 32'd1);
      repeat (3) tick();
      chk("t5_cen3", 32'(count_enb), 32'd1);
      rst_ = 1'b0;
      req  = 4'b1010;
      set_op(1, 8'h11, 1'b1, 2);
      set_op(3, 8'h00, 1'b0, 1);
      tick();
      chk("t5_gnt", 32'(gnt), 32'd0);
      chk("t5_cen", 32'(count_enb), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_done", 32'(done), 32'd0);
      rst_ = 1'b1;
      run_job(1, 8'h11, 1'b1, 8'h13, 2, -1, 1'b0);
      run_job(3, 8'h00, 1'b0, 8'hFF, 1, -1, 1'b0);

      // T6 requester drops mid-COUNT; requester 2 waits behind it
      set_op(0, 8'h20, 1'b1, 7);
      set_op(2, 8'h7F, 1'b1, 1);
      req = 4'b0101;
      run_job(0, 8'h20, 1'b1, 8'h27, 7, 2, 1'b0);
      run_job(2, 8'h7F, 1'b1, 8'h80, 1, -1, 1'b0);

      inv_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
